// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a synchronous-read imem, presents IR/PC to IF/ID.
// Latency: one cycle from imem_addr to IR_out/PC_out; redirect costs exactly one bubble.
// Backpressure: EN=0 holds PC state and re-reads the held address so IR_out stays stable.
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   EN                  IF/ID enable (0 = stall)
//   redirect            EX-stage taken branch/jump
//   redirect_pc         redirect target (bits [1:0] ignored)
//   imem_addr           address to synchronous instruction memory
//   imem_rdata          memory data for last cycle's address
//   IR_out, PC_out      instruction and its PC toward IF/ID
//   CLR                 IF/ID clear (bubble insert)
//   fetch_cnt           instructions accepted by IF/ID
//   stall_cnt           cycles a valid instruction was held by EN=0
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EN,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IR_out,
    output logic [31:0] PC_out,
    output logic        CLR,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    logic [31:0] fetch_pc;
    logic [31:0] resp_pc;
    logic        resp_valid;

    logic [31:0] target_pc;
    logic        advance;
    logic        count_fetch;
    logic        count_stall;

    assign target_pc   = {redirect_pc[31:2], 2'b00};
    // A new address is issued whenever IF/ID consumes the current one, or
    // when nothing valid is outstanding yet (startup / after reset).
    assign advance     = EN | ~resp_valid;
    assign count_fetch = EN & resp_valid & ~redirect;
    assign count_stall = ~EN & resp_valid & ~redirect;

    assign IR_out = imem_rdata;
    assign PC_out = resp_pc;

    always_comb begin
        imem_addr = fetch_pc;
        CLR       = 1'b0;
        if (!rst_n) begin
            imem_addr = RESET_PC;
            CLR       = 1'b1;
        end else if (redirect) begin
            imem_addr = target_pc;
            CLR       = 1'b1;
        end else if (advance) begin
            imem_addr = fetch_pc;
            // Bubble only while IF/ID is actually capturing; a stalled
            // ID-stage instruction must never be cleared.
            CLR       = ~resp_valid & EN;
        end else begin
            // Re-read the held address so the sync memory keeps IR_out stable.
            imem_addr = resp_pc;
            CLR       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc   <= RESET_PC;
            resp_pc    <= 32'h0000_0000;
            resp_valid <= 1'b0;
            fetch_cnt  <= 32'h0000_0000;
            stall_cnt  <= 32'h0000_0000;
        end else begin
            if (redirect) begin
                resp_pc    <= target_pc;
                resp_valid <= 1'b1;
                fetch_pc   <= target_pc + 32'd4;
            end else if (advance) begin
                resp_pc    <= fetch_pc;
                resp_valid <= 1'b1;
                fetch_pc   <= fetch_pc + 32'd4;
            end
            if (count_fetch) fetch_cnt <= fetch_cnt + 32'd1;
            if (count_stall) stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule
